pipelined_addsub: RTL and testbench

- Parametrised, pipelined successor to the 32-bit combinational adder in the datapath.
- Computes a+b or a-b over WIDTH bits. The carry chain is split into STAGES equal slices, one slice per clock.
- Uses a valid/ready handshake so the execute stage can issue one operation per cycle and stall on backpressure.
- Produces LEGv8 NZVC flags for ADDS/SUBS.

---
 rtl/pipelined_addsub.sv | 152 +++++++++++++++
 tb/tb_pipelined_addsub.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipelined_addsub.sv
// Pipelined WIDTH-bit adder/subtractor: the carry chain is cut into STAGES slices, one per clock.
// Define PIPE_ADDSUB_FLAGS_EN to build the registered NZVC flags; otherwise the flag ports read 0.
module pipelined_addsub #(
    parameter int WIDTH  = 64,
    parameter int STAGES = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    input  logic             sub_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             flag_n,
    output logic             flag_z,
    output logic             flag_v,
    output logic             flag_c
);
    localparam int SW = WIDTH / STAGES;

    if (STAGES < 1 || STAGES > WIDTH || (WIDTH % STAGES) != 0) begin : g_bad_cfg
        $error("pipelined_addsub: WIDTH must be a multiple of STAGES, 1 <= STAGES <= WIDTH");
    end

    // Handshake: a transfer happens on a side only when its valid and ready are both high
    // at a rising edge. The whole pipe advances together whenever the output slot is free
    // or being drained, so in_ready is that same global enable.
    logic             en;
    logic [WIDTH-1:0] b_cond;

    assign en       = !out_valid || out_ready;
    assign in_ready = en;
    assign b_cond   = sub_in ? ~b_in : b_in;

    // Stages 0..STAGES-2 keep the unconsumed operand bits and the finished low result bits.
    for (genvar k = 0; k < STAGES - 1; k++) begin : g_stage
        localparam int IN_W   = WIDTH - k * SW;
        localparam int REM_W  = IN_W - SW;
        localparam int DONE_W = (k + 1) * SW;

        logic [IN_W-1:0]   a_d, b_d;
        logic              c_d, v_d;
        logic [SW:0]       slice;
        logic [DONE_W-1:0] r_d;
        logic              v_q, c_q;
        logic [REM_W-1:0]  a_q, b_q;
        logic [DONE_W-1:0] r_q;

        if (k == 0) begin : g_head
            assign a_d = a_in;
            assign b_d = b_cond;
            assign c_d = sub_in;
            assign v_d = in_valid;
            assign r_d = slice[SW-1:0];
        end else begin : g_body
            assign a_d = g_stage[k-1].a_q;
            assign b_d = g_stage[k-1].b_q;
            assign c_d = g_stage[k-1].c_q;
            assign v_d = g_stage[k-1].v_q;
            assign r_d = {slice[SW-1:0], g_stage[k-1].r_q};
        end

        assign slice = (SW+1)'(a_d[SW-1:0]) + (SW+1)'(b_d[SW-1:0]) + (SW+1)'(c_d);

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                v_q <= 1'b0;
                c_q <= 1'b0;
                a_q <= '0;
                b_q <= '0;
                r_q <= '0;
            end else if (en) begin
                v_q <= v_d;
                c_q <= slice[SW];
                a_q <= a_d[IN_W-1:SW];
                b_q <= b_d[IN_W-1:SW];
                r_q <= r_d;
            end
        end
    end

    // Final stage: top slice, then the full result (and flags) land in the output registers.
    logic [SW-1:0]    fa, fb, f_slice;
    logic             fc, fv;
    logic [WIDTH-1:0] f_sum;
    logic             v_out_q;
    logic [WIDTH-1:0] sum_q;

    if (STAGES == 1) begin : g_single
        assign fa    = a_in;
        assign fb    = b_cond;
        assign fc    = sub_in;
        assign fv    = in_valid;
        assign f_sum = f_slice;
    end else begin : g_tail
        assign fa    = g_stage[STAGES-2].a_q;
        assign fb    = g_stage[STAGES-2].b_q;
        assign fc    = g_stage[STAGES-2].c_q;
        assign fv    = g_stage[STAGES-2].v_q;
        assign f_sum = {f_slice, g_stage[STAGES-2].r_q};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v_out_q <= 1'b0;
            sum_q   <= '0;
        end else if (en) begin
            v_out_q <= fv;
            sum_q   <= f_sum;
        end
    end

    assign out_valid = v_out_q;
    assign sum       = sum_q;

`ifdef PIPE_ADDSUB_FLAGS_EN
    logic f_co;
    logic n_q, z_q, v_q, c_q;

    assign {f_co, f_slice} = (SW+1)'(fa) + (SW+1)'(fb) + (SW+1)'(fc);

    // fb already holds the conditioned operand, so one overflow rule covers add and subtract.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            n_q <= 1'b0;
            z_q <= 1'b0;
            v_q <= 1'b0;
            c_q <= 1'b0;
        end else if (en) begin
            n_q <= f_sum[WIDTH-1];
            z_q <= (f_sum == '0);
            v_q <= (fa[SW-1] == fb[SW-1]) && (f_sum[WIDTH-1] != fa[SW-1]);
            c_q <= f_co;
        end
    end

    assign flag_n = n_q;
    assign flag_z = z_q;
    assign flag_v = v_q;
    assign flag_c = c_q;
`else
    assign f_slice = fa + fb + SW'(fc);
    assign flag_n  = 1'b0;
    assign flag_z  = 1'b0;
    assign flag_v  = 1'b0;
    assign flag_c  = 1'b0;
`endif

endmodule

// File: tb/tb_pipelined_addsub.sv
// Bench for pipelined_addsub (WIDTH=64, STAGES=4): directed scenarios plus a queue scoreboard.
// Flag expectations follow PIPE_ADDSUB_FLAGS_EN; without it all flags must read 0.
module tb_pipelined_addsub;
  localparam int WIDTH  = 64;
  localparam int STAGES = 4;
  localparam int W      = WIDTH + 4;
`ifdef PIPE_ADDSUB_FLAGS_EN
  localparam bit FLAGS_ON = 1'b1;
`else
  localparam bit FLAGS_ON = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [WIDTH-1:0] a_in = '0;
  logic [WIDTH-1:0] b_in = '0;
  logic             sub_in = 1'b0;
  logic             out_valid;
  logic             out_ready = 1'b1;
  logic [WIDTH-1:0] sum;
  logic             flag_n, flag_z, flag_v, flag_c;

  int          n_vec = 0;
  int          n_err = 0;
  int          n_out = 0;
  longint      cyc = 0;
  bit          check_lat = 1'b0;
  logic [W-1:0] exp_q[$];
  longint      iss_q[$];
  logic [W-1:0] exp_item;
  longint      iss_item;
  logic [3:0]  fm;

  pipelined_addsub #(.WIDTH(WIDTH), .STAGES(STAGES)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a_in(a_in), .b_in(b_in), .sub_in(sub_in), .out_valid(out_valid),
    .out_ready(out_ready), .sum(sum), .flag_n(flag_n), .flag_z(flag_z),
    .flag_v(flag_v), .flag_c(flag_c)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation exceeded time limit, n_err=%0d", n_err);
    $fatal(1, "watchdog");
  end

  // Reference model: arithmetic written as plain a+b / a-b, not sliced.
  function automatic logic [W-1:0] model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                         input logic sub);
    logic [WIDTH:0]   ext;
    logic [WIDTH-1:0] s;
    logic             n, z, v, c;
    if (sub) begin
      s = a - b;
      c = (a >= b);
      v = (a[WIDTH-1] != b[WIDTH-1]) && (s[WIDTH-1] != a[WIDTH-1]);
    end else begin
      ext = {1'b0, a} + {1'b0, b};
      s = ext[WIDTH-1:0];
      c = ext[WIDTH];
      v = (a[WIDTH-1] == b[WIDTH-1]) && (s[WIDTH-1] != a[WIDTH-1]);
    end
    n = s[WIDTH-1];
    z = (s == '0);
    return {s, {n, z, v, c} & {4{FLAGS_ON}}};
  endfunction

  // ---------------- scoreboard ----------------
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      n_vec++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL sb_extra: got sum=%h with no result outstanding", sum);
      end else begin
        exp_item = exp_q.pop_front();
        iss_item = iss_q.pop_front();
        n_out++;
        if ({sum, flag_n, flag_z, flag_v, flag_c} !== exp_item) begin
          n_err++;
          $display("FAIL sb_result: got sum=%h nzvc=%b, required sum=%h nzvc=%b",
                   sum, {flag_n, flag_z, flag_v, flag_c}, exp_item[W-1:4], exp_item[3:0]);
        end
        if (check_lat) begin
          n_vec++;
          if (cyc - iss_item != STAGES) begin
            n_err++;
            $display("FAIL sb_latency: got %0d cycles, required %0d", cyc - iss_item, STAGES);
          end
        end
      end
    end
    if (rst_n && in_valid && in_ready) begin
      exp_q.push_back(model(a_in, b_in, sub_in));
      iss_q.push_back(cyc);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic wait_drain(input int budget);
    int t = 0;
    while (exp_q.size() != 0 && t < budget) begin
      @(posedge clk);
      t++;
    end
    #1;
    n_vec++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL drain: %0d results outstanding after %0d cycles, required 0", exp_q.size(), budget);
    end
  endtask

  task automatic send_one(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic sub,
                          output logic [WIDTH-1:0] s, output logic [3:0] f, output int lat);
    @(posedge clk); #1;
    a_in = a; b_in = b; sub_in = sub; in_valid = 1'b1; out_ready = 1'b1;
    lat = 0;
    do begin
      @(posedge clk); #1;
      in_valid = 1'b0;
      lat++;
    end while (!out_valid && lat < 50);
    s = sum;
    f = {flag_n, flag_z, flag_v, flag_c};
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_vec++;
    if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b required 0", out_valid); end
    n_vec++;
    if (sum !== '0) begin n_err++; $display("FAIL reset_sum: got %h required 0", sum); end
    n_vec++;
    if ({flag_n, flag_z, flag_v, flag_c} !== 4'b0000) begin
      n_err++; $display("FAIL reset_flags: got %b required 0000", {flag_n, flag_z, flag_v, flag_c});
    end
    @(negedge clk) rst_n = 1'b1;
    #1;
    n_vec++;
    if (in_ready !== 1'b1) begin n_err++; $display("FAIL reset_ready: got %b required 1", in_ready); end
  endtask

  task automatic test_carry;
    logic [WIDTH-1:0] s; logic [3:0] f; int lat;
    send_one(64'h0000_0000_FFFF_FFFF, 64'd1, 1'b0, s, f, lat);
    n_vec++;
    if (lat != STAGES) begin n_err++; $display("FAIL carry_latency: got %0d required %0d", lat, STAGES); end
    n_vec++;
    if (s !== 64'h0000_0001_0000_0000) begin n_err++; $display("FAIL carry_slice_sum: got %h required 100000000", s); end
    n_vec++;
    if (f !== (4'b0000 & fm)) begin n_err++; $display("FAIL carry_slice_flags: got %b required %b", f, 4'b0000 & fm); end
    send_one(64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, s, f, lat);
    n_vec++;
    if (s !== '0) begin n_err++; $display("FAIL carry_wrap_sum: got %h required 0", s); end
    n_vec++;
    if (f !== (4'b0101 & fm)) begin n_err++; $display("FAIL carry_wrap_flags: got %b required %b", f, 4'b0101 & fm); end
    wait_drain(10);
  endtask

  task automatic test_subtract;
    logic [WIDTH-1:0] s; logic [3:0] f; int lat;
    send_one(64'd5, 64'd7, 1'b1, s, f, lat);
    n_vec++;
    if (s !== 64'hFFFF_FFFF_FFFF_FFFE) begin n_err++; $display("FAIL sub_borrow_sum: got %h required FFFFFFFFFFFFFFFE", s); end
    n_vec++;
    if (f !== (4'b1000 & fm)) begin n_err++; $display("FAIL sub_borrow_flags: got %b required %b", f, 4'b1000 & fm); end
    send_one(64'h8000_0000_0000_0000, 64'd1, 1'b1, s, f, lat);
    n_vec++;
    if (s !== 64'h7FFF_FFFF_FFFF_FFFF) begin n_err++; $display("FAIL sub_ovf_sum: got %h required 7FFFFFFFFFFFFFFF", s); end
    n_vec++;
    if (f !== (4'b0011 & fm)) begin n_err++; $display("FAIL sub_ovf_flags: got %b required %b", f, 4'b0011 & fm); end
    wait_drain(10);
  endtask

  task automatic test_streaming;
    int start_out;
    start_out = n_out;
    check_lat = 1'b1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < 10100; i++) begin
      a_in = 64'(i); b_in = 64'(i + 1); sub_in = 1'b0; in_valid = 1'b1;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    wait_drain(20);
    check_lat = 1'b0;
    n_vec++;
    if (n_out - start_out != 10100) begin
      n_err++; $display("FAIL stream_count: got %0d results required 10100", n_out - start_out);
    end
  endtask

  task automatic test_back_to_back_stall;
    logic [W-1:0] snap; int t;
    out_ready = 1'b1;
    @(posedge clk); #1;
    for (int j = 0; j < 3; j++) begin
      a_in = {$urandom, $urandom}; b_in = {$urandom, $urandom}; sub_in = 1'($urandom_range(0, 1));
      in_valid = 1'b1;
      @(posedge clk); #1;
    end
    in_valid = 1'b0; out_ready = 1'b0;
    t = 0;
    while (!out_valid && t < 10) begin @(posedge clk); #1; t++; end
    n_vec++;
    if (out_valid !== 1'b1) begin n_err++; $display("FAIL stall_arrive: got out_valid=%b required 1", out_valid); end
    snap = {sum, flag_n, flag_z, flag_v, flag_c};
    a_in = {$urandom, $urandom}; b_in = {$urandom, $urandom}; sub_in = 1'b1; in_valid = 1'b1;
    for (int j = 0; j < 5; j++) begin
      @(posedge clk); #1;
      n_vec++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
        n_err++; $display("FAIL stall_hs: got out_valid=%b in_ready=%b required 1/0", out_valid, in_ready);
      end
      n_vec++;
      if ({sum, flag_n, flag_z, flag_v, flag_c} !== snap) begin
        n_err++; $display("FAIL stall_hold: got %h required %h", {sum, flag_n, flag_z, flag_v, flag_c}, snap);
      end
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    wait_drain(20);
  endtask

  task automatic test_reset_mid;
    logic [WIDTH-1:0] a, b, s; logic [3:0] f; int lat;
    out_ready = 1'b0;
    @(posedge clk); #1;
    for (int j = 0; j < 4; j++) begin
      a_in = {$urandom, $urandom}; b_in = {$urandom, $urandom}; sub_in = 1'b0; in_valid = 1'b1;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    @(negedge clk); #2;
    rst_n = 1'b0;
    #1;
    exp_q.delete(); iss_q.delete();
    n_vec++;
    if (out_valid !== 1'b0 || sum !== '0) begin
      n_err++; $display("FAIL rst_mid_clear: got out_valid=%b sum=%h required 0/0", out_valid, sum);
    end
    #3;
    rst_n = 1'b1;
    out_ready = 1'b1;
    for (int j = 0; j < 8; j++) begin
      @(posedge clk); #1;
      n_vec++;
      if (out_valid !== 1'b0) begin n_err++; $display("FAIL rst_mid_stale: got out_valid=1 sum=%h required no output", sum); end
    end
    a = {$urandom, $urandom}; b = {$urandom, $urandom};
    send_one(a, b, 1'b0, s, f, lat);
    n_vec++;
    if (lat != STAGES) begin n_err++; $display("FAIL rst_mid_latency: got %0d required %0d", lat, STAGES); end
    n_vec++;
    if (s !== a + b) begin n_err++; $display("FAIL rst_mid_sum: got %h required %h", s, a + b); end
    wait_drain(10);
  endtask

  task automatic test_random;
    logic [WIDTH-1:0] corner[4];
    corner[0] = '0; corner[1] = '1; corner[2] = 64'h8000_0000_0000_0000; corner[3] = 64'h7FFF_FFFF_FFFF_FFFF;
    for (int j = 0; j < 400; j++) begin
      @(posedge clk); #1;
      in_valid  = ($urandom_range(0, 9) < 7);
      out_ready = ($urandom_range(0, 9) < 7);
      sub_in    = 1'($urandom_range(0, 1));
      a_in = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 3)] : {$urandom, $urandom};
      b_in = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 3)] : {$urandom, $urandom};
    end
    @(posedge clk); #1;
    in_valid = 1'b0; out_ready = 1'b1;
    wait_drain(50);
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    fm = {4{FLAGS_ON}};
    test_reset();
    test_carry();
    test_subtract();
    test_streaming();
    test_back_to_back_stall();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
